vt52_command_handler: RTL
=========================

Name: vt52_command_handler

Overview:
- Upstream stage of the character buffer.
- Consumes the host byte stream (UART RX FIFO) over a valid/ready handshake.
- Interprets printable characters, C0 controls and VT52 escape sequences, and produces buffer writes, scroll requests and the cursor position.
- Owns the cursor; the video stage reads cursor_x/cursor_y for the cursor overlay.

Parameters:
- ADDR_BITS, 11, buffer address width.
- COLS, 80, columns per row.
- ROWS, 25, rows addressable by the cursor; must match the character buffer.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data  in  8  incoming host byte
- valid  in  1  data valid
- ready  out  1  byte accepted on any clk edge where valid && ready
- buffer_din  out  8  character to write
- buffer_waddr  out  ADDR_BITS  write address, cursor_y*COLS + cursor_x
- buffer_wen  out  1  one-cycle write strobe
- scroll  out  1  one-cycle scroll request
- scroll_done  in  1  one-cycle pulse from the buffer when the scroll completes
- cursor_x  out  7  column, 0..COLS-1
- cursor_y  out  5  row, 0..ROWS-1
- tx_data  out  8  response byte (see optional feature)
- tx_valid  out  1  response valid
- tx_ready  in  1  response accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state NORMAL, cursor_x=0, cursor_y=0, buffer_wen=0, buffer_din=0x20, buffer_waddr=0, scroll=0, tx_valid=0, tx_data=0.
- Reset mid-operation: aborts any ERASE, SCROLL_WAIT or escape sequence immediately.
- ready: combinational decode of state. High in NORMAL, ESC, Y_ROW, Y_COL. Low in ERASE, SCROLL_WAIT, IDENT.
- Registered outputs: all other outputs are registered. Effects appear on the edge after the accepting edge.
- States: NORMAL, ESC, Y_ROW, Y_COL, ERASE, SCROLL_WAIT, IDENT.
- NORMAL, printable byte (0x20-0x7E, 0x80-0xFF):
  - buffer_din=byte, buffer_waddr=current address, buffer_wen=1 for one cycle.
  - cursor_x+1, saturating at COLS-1. There is no autowrap; later characters overwrite the last column.
- NORMAL, controls:
  - 0x0D CR: cursor_x=0.
  - 0x08 BS: cursor_x-1, saturating at 0.
  - 0x09 TAB: cursor_x = (cursor_x|7)+1, capped at COLS-1.
  - 0x0A LF: if cursor_y<ROWS-1, cursor_y+1. Otherwise pulse scroll for one cycle, enter SCROLL_WAIT, and leave cursor_y at ROWS-1.
  - 0x1B: go to ESC.
  - All other controls and 0x7F: ignored, no write.
- SCROLL_WAIT: stays until scroll_done, then returns to NORMAL. No writes are issued while waiting.
- ESC, next byte:
  - 'A': cursor_y-1, saturating at 0.
  - 'B': cursor_y+1, saturating at ROWS-1.
  - 'C': cursor_x+1, saturating at COLS-1.
  - 'D': cursor_x-1, saturating at 0.
  - 'H': cursor to 0,0.
  - 'I': cursor_y-1 if cursor_y>0; at row 0 no action (no reverse scroll).
  - 'Y': go to Y_ROW.
  - 'J': ERASE from the cursor address to ROWS*COLS-1 inclusive.
  - 'K': ERASE from the cursor address to cursor_y*COLS+COLS-1 inclusive.
  - 'Z': see optional feature.
  - Any other byte, including ESC: discarded.
  - Every case except Y, J, K and an enabled Z returns to NORMAL.
- Y_ROW: row = byte-0x20, clamped to 0..ROWS-1. Bytes below 0x20 give 0. Go to Y_COL.
- Y_COL: col = byte-0x20, clamped to 0..COLS-1. Cursor row and column update together on this edge. Return to NORMAL.
- ERASE:
  - One write of 0x20 per cycle, starting with the first write on the edge after acceptance. Address increments by 1.
  - Cursor is unchanged.
  - After the last address, buffer_wen=0 and state returns to NORMAL.
  - Write count: 'K' = COLS-cursor_x; 'J' = ROWS*COLS-(cursor_y*COLS+cursor_x).
- Arithmetic: address = cursor_y*COLS+cursor_x, computed at ADDR_BITS width with no overflow for the default parameters.

Optional Feature:
- Macro: VT52_IDENTIFY_EN.
- Defined: ESC 'Z' enters IDENT and sends 0x1B, 0x2F, 0x4B on tx_data/tx_valid. Each byte is held until tx_ready. After the third byte is accepted, return to NORMAL. ready stays low throughout.
- Not defined: ESC 'Z' is discarded like any unknown final byte. tx_valid and tx_data are tied to 0.

Test Plan:
- Reset, then send 'A','B' -> writes 0x41@0 and 0x42@1; cursor_x=2, cursor_y=0; buffer_wen high exactly 2 cycles.
- Send ESC 'Y' 0x25 0x2A -> cursor_y=5, cursor_x=10, no write. Then 'X' -> write 0x58@410.
- Cursor at row 24 (ROWS-1), send LF -> single scroll pulse, ready low until scroll_done. Cursor stays at row 24; the byte after scroll_done is accepted.
- Cursor at 3,78, send ESC 'K' -> writes of 0x20 at addresses 318 and 319 only, ready low 2 cycles, cursor unchanged. Cursor at 24,0, send ESC 'J' -> 80 writes at 1920..1999.
- Send 80 printable bytes from column 0, then TAB at column 70, BS at 0 and ESC 'Y' 0x7F 0x7F -> cursor_x saturates at 79 with the last byte overwriting column 79; TAB gives 72, then 79 on the next TAB; BS stays at 0; ESC Y clamps to 24,79.
- Assert reset during an ESC 'J' erase -> next cycle buffer_wen=0, ready=1, cursor 0,0. With VT52_IDENTIFY_EN defined: ESC 'Z' -> tx sequence 1B 2F 4B honoured under tx_ready stalls.

Source files
------------

// File: rtl/vt52_command_handler.sv
// VT52 host-byte interpreter: printable bytes, C0 controls and ESC sequences become buffer writes,
// scroll requests and cursor moves. Define VT52_IDENTIFY_EN to answer ESC Z on the tx port.
module vt52_command_handler #(
    parameter int ADDR_BITS = 11,
    parameter int COLS      = 80,
    parameter int ROWS      = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           data,
    input  logic                 valid,
    output logic                 ready,
    output logic [7:0]           buffer_din,
    output logic [ADDR_BITS-1:0] buffer_waddr,
    output logic                 buffer_wen,
    output logic                 scroll,
    input  logic                 scroll_done,
    output logic [6:0]           cursor_x,
    output logic [4:0]           cursor_y,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready
);
    typedef enum logic [2:0] {
        NORMAL      = 3'd0,
        ESC         = 3'd1,
        Y_ROW       = 3'd2,
        Y_COL       = 3'd3,
        ERASE       = 3'd4,
        SCROLL_WAIT = 3'd5,
        IDENT       = 3'd6
    } state_t;

    localparam logic [6:0]           COL_MAX    = 7'(COLS - 1);
    localparam logic [4:0]           ROW_MAX    = 5'(ROWS - 1);
    localparam logic [ADDR_BITS-1:0] SCREEN_END = ADDR_BITS'(ROWS * COLS - 1);

    state_t               state_r, state_s;
    logic [6:0]           cursor_x_r, cursor_x_s;
    logic [4:0]           cursor_y_r, cursor_y_s;
    logic [4:0]           row_r, row_s;
    logic [7:0]           din_r, din_s;
    logic [ADDR_BITS-1:0] waddr_r, waddr_s;
    logic                 wen_r, wen_s;
    logic                 scroll_r, scroll_s;
    logic [ADDR_BITS-1:0] erase_addr_r, erase_addr_s;
    logic [ADDR_BITS-1:0] erase_end_r, erase_end_s;
    logic [7:0]           tx_data_r, tx_data_s;
    logic                 tx_valid_r, tx_valid_s;
    logic [1:0]           id_idx_r, id_idx_s;

    logic                 ready_s, accept_s, printable_s;
    logic [ADDR_BITS-1:0] row_base_s, cur_addr_s, row_end_s;
    logic [6:0]           x_inc_s, x_dec_s, x_tab_s, col_val_s;
    logic [4:0]           y_inc_s, y_dec_s, row_val_s;
    logic [7:0]           tab_raw_s, offs_s;

    // Byte acceptance is a pure decode of the state
    always_comb begin
        case (state_r)
            NORMAL, ESC, Y_ROW, Y_COL: ready_s = 1'b1;
            default:                   ready_s = 1'b0;
        endcase
    end

    // Cursor arithmetic shared by controls, escapes and direct addressing
    always_comb begin
        accept_s    = valid && ready_s;
        printable_s = (data >= 8'h20) && (data != 8'h7F);
        row_base_s  = ADDR_BITS'(cursor_y_r) * ADDR_BITS'(COLS);
        cur_addr_s  = row_base_s + ADDR_BITS'(cursor_x_r);
        row_end_s   = row_base_s + ADDR_BITS'(COLS - 1);
        x_inc_s     = (cursor_x_r >= COL_MAX) ? COL_MAX : cursor_x_r + 7'd1;
        x_dec_s     = (cursor_x_r == 7'd0) ? 7'd0 : cursor_x_r - 7'd1;
        y_inc_s     = (cursor_y_r >= ROW_MAX) ? ROW_MAX : cursor_y_r + 5'd1;
        y_dec_s     = (cursor_y_r == 5'd0) ? 5'd0 : cursor_y_r - 5'd1;
        tab_raw_s   = {1'b0, cursor_x_r | 7'd7} + 8'd1;
        x_tab_s     = (tab_raw_s > {1'b0, COL_MAX}) ? COL_MAX : tab_raw_s[6:0];
        offs_s      = data - 8'h20;
        // ESC Y coordinates are biased by 0x20; anything below the bias pins to 0
        if (data < 8'h20) begin
            row_val_s = 5'd0;
            col_val_s = 7'd0;
        end else begin
            row_val_s = (offs_s > {3'b000, ROW_MAX}) ? ROW_MAX : offs_s[4:0];
            col_val_s = (offs_s > {1'b0, COL_MAX}) ? COL_MAX : offs_s[6:0];
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_s      = state_r;
        cursor_x_s   = cursor_x_r;
        cursor_y_s   = cursor_y_r;
        row_s        = row_r;
        din_s        = din_r;
        waddr_s      = waddr_r;
        wen_s        = 1'b0;
        scroll_s     = 1'b0;
        erase_addr_s = erase_addr_r;
        erase_end_s  = erase_end_r;
        tx_data_s    = tx_data_r;
        tx_valid_s   = tx_valid_r;
        id_idx_s     = id_idx_r;
        case (state_r)
            NORMAL: begin
                if (accept_s && printable_s) begin
                    din_s      = data;
                    waddr_s    = cur_addr_s;
                    wen_s      = 1'b1;
                    cursor_x_s = x_inc_s;
                end else if (accept_s) begin
                    case (data)
                        8'h0D: cursor_x_s = 7'd0;
                        8'h08: cursor_x_s = x_dec_s;
                        8'h09: cursor_x_s = x_tab_s;
                        8'h0A: begin
                            if (cursor_y_r < ROW_MAX) begin
                                cursor_y_s = y_inc_s;
                            end else begin
                                scroll_s = 1'b1;
                                state_s  = SCROLL_WAIT;
                            end
                        end
                        8'h1B:   state_s = ESC;
                        default: state_s = NORMAL;
                    endcase
                end else begin
                    state_s = NORMAL;
                end
            end
            ESC: begin
                if (accept_s) begin
                    state_s = NORMAL;
                    case (data)
                        8'h41: cursor_y_s = y_dec_s;
                        8'h42: cursor_y_s = y_inc_s;
                        8'h43: cursor_x_s = x_inc_s;
                        8'h44: cursor_x_s = x_dec_s;
                        8'h48: begin
                            cursor_x_s = 7'd0;
                            cursor_y_s = 5'd0;
                        end
                        // Reverse index without reverse scroll behaves like cursor up
                        8'h49: cursor_y_s = y_dec_s;
                        8'h59: state_s = Y_ROW;
                        8'h4A: begin
                            state_s      = ERASE;
                            erase_addr_s = cur_addr_s;
                            erase_end_s  = SCREEN_END;
                        end
                        8'h4B: begin
                            state_s      = ERASE;
                            erase_addr_s = cur_addr_s;
                            erase_end_s  = row_end_s;
                        end
                        8'h5A: begin
`ifdef VT52_IDENTIFY_EN
                            state_s    = IDENT;
                            tx_valid_s = 1'b1;
                            tx_data_s  = 8'h1B;
                            id_idx_s   = 2'd0;
`else
                            state_s = NORMAL;
`endif
                        end
                        default: state_s = NORMAL;
                    endcase
                end else begin
                    state_s = ESC;
                end
            end
            Y_ROW: begin
                if (accept_s) begin
                    row_s   = row_val_s;
                    state_s = Y_COL;
                end else begin
                    state_s = Y_ROW;
                end
            end
            Y_COL: begin
                if (accept_s) begin
                    cursor_y_s = row_r;
                    cursor_x_s = col_val_s;
                    state_s    = NORMAL;
                end else begin
                    state_s = Y_COL;
                end
            end
            ERASE: begin
                din_s   = 8'h20;
                waddr_s = erase_addr_r;
                wen_s   = 1'b1;
                if (erase_addr_r == erase_end_r) begin
                    state_s = NORMAL;
                end else begin
                    erase_addr_s = erase_addr_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                end
            end
            SCROLL_WAIT: begin
                if (scroll_done) begin
                    state_s = NORMAL;
                end else begin
                    state_s = SCROLL_WAIT;
                end
            end
            IDENT: begin
                if (tx_valid_r && tx_ready) begin
                    case (id_idx_r)
                        2'd0: begin
                            tx_data_s = 8'h2F;
                            id_idx_s  = 2'd1;
                        end
                        2'd1: begin
                            tx_data_s = 8'h4B;
                            id_idx_s  = 2'd2;
                        end
                        default: begin
                            tx_valid_s = 1'b0;
                            id_idx_s   = 2'd0;
                            state_s    = NORMAL;
                        end
                    endcase
                end else begin
                    state_s = IDENT;
                end
            end
            default: state_s = NORMAL;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= NORMAL;
            cursor_x_r   <= 7'd0;
            cursor_y_r   <= 5'd0;
            row_r        <= 5'd0;
            din_r        <= 8'h20;
            waddr_r      <= {ADDR_BITS{1'b0}};
            wen_r        <= 1'b0;
            scroll_r     <= 1'b0;
            erase_addr_r <= {ADDR_BITS{1'b0}};
            erase_end_r  <= {ADDR_BITS{1'b0}};
            tx_data_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            id_idx_r     <= 2'd0;
        end else begin
            state_r      <= state_s;
            cursor_x_r   <= cursor_x_s;
            cursor_y_r   <= cursor_y_s;
            row_r        <= row_s;
            din_r        <= din_s;
            waddr_r      <= waddr_s;
            wen_r        <= wen_s;
            scroll_r     <= scroll_s;
            erase_addr_r <= erase_addr_s;
            erase_end_r  <= erase_end_s;
            tx_data_r    <= tx_data_s;
            tx_valid_r   <= tx_valid_s;
            id_idx_r     <= id_idx_s;
        end
    end

    assign ready        = ready_s;
    assign buffer_din   = din_r;
    assign buffer_waddr = waddr_r;
    assign buffer_wen   = wen_r;
    assign scroll       = scroll_r;
    assign cursor_x     = cursor_x_r;
    assign cursor_y     = cursor_y_r;
`ifdef VT52_IDENTIFY_EN
    assign tx_data      = tx_data_r;
    assign tx_valid     = tx_valid_r;
`else
    assign tx_data      = 8'h00;
    assign tx_valid     = 1'b0;
`endif

endmodule
